// File: rtl/and_8_bits_sequencer.sv
// Sequencer for an external 8-bit AND stage: registers an operand pair, waits
// SETTLE_CYCLES for the stage to settle, then captures and hands off the result.
module and_8_bits_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic [7:0] and_a,
  output logic [7:0] and_b,
  input  logic [7:0] and_s,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       mismatch,
  output logic [7:0] result_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   and_a_q, and_a_d;
  logic [DATA_W-1:0]   and_b_q, and_b_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic                mismatch_q, mismatch_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  // State register; handshake flags are registered from the next state so they
  // stay low throughout reset and rise on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      and_a_q     <= '0;
      and_b_q     <= '0;
      out_data_q  <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      and_a_q     <= and_a_d;
      and_b_q     <= and_b_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      mismatch_q  <= mismatch_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    and_a_d    = and_a_q;
    and_b_d    = and_b_q;
    out_data_d = out_data_q;
    count_d    = count_q;
    mismatch_d = mismatch_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          and_a_d = a_in;
          and_b_d = b_in;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_data_d = and_s;
          state_d    = DONE;
          if (and_s != (and_a_q & and_b_q)) begin
            mismatch_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          count_d = count_q + DATA_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign and_a        = and_a_q;
  assign and_b        = and_b_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign mismatch     = mismatch_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_and_8_bits_sequencer.sv
// Bench for and_8_bits_sequencer: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_and_8_bits_sequencer;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic [7:0] fault_mask = '0;
  logic       in_ready, out_valid, busy, mismatch;
  logic [7:0] and_a, and_b, and_s, out_data, result_count;

  // Second pair of DUTs for latency corner cases
  logic       in_valid_x = 1'b0;
  logic [7:0] a_x = '0, b_x = '0;
  logic       rdy1, ov1, busy1, mis1, rdy15, ov15, busy15, mis15;
  logic [7:0] aa1, ab1, as1, od1, rc1, aa15, ab15, as15, od15, rc15;

  int n_checks = 0;
  int n_errors = 0;
  int tb_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  assign and_s = (and_a & and_b) & ~fault_mask;
  assign as1   = aa1 & ab1;
  assign as15  = aa15 & ab15;

  and_8_bits_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .and_a(and_a), .and_b(and_b), .and_s(and_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .mismatch(mismatch), .result_count(result_count));

  and_8_bits_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(rdy1),
    .a_in(a_x), .b_in(b_x), .and_a(aa1), .and_b(ab1), .and_s(as1),
    .out_valid(ov1), .out_ready(1'b1), .out_data(od1),
    .busy(busy1), .mismatch(mis1), .result_count(rc1));

  and_8_bits_sequencer #(.SETTLE_CYCLES(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(rdy15),
    .a_in(a_x), .b_in(b_x), .and_a(aa15), .and_b(ab15), .and_s(as15),
    .out_valid(ov15), .out_ready(1'b1), .out_data(od15),
    .busy(busy15), .mismatch(mis15), .result_count(rc15));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted pair is captured S edges later and retired
  // on the first edge that sees downstream ready.
  logic       m_rdy, m_txn, m_valid, m_mis;
  logic [7:0] m_a, m_b, m_data, m_cnt;
  int         m_cyc, m_cap_at;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 1'b0; m_txn <= 1'b0; m_valid <= 1'b0; m_mis <= 1'b0;
      m_a <= '0; m_b <= '0; m_data <= '0; m_cnt <= '0; m_cap_at <= 0;
    end else begin
      m_rdy <= 1'b1;
      m_cyc <= m_cyc + 1;
      if (m_rdy && !m_txn) begin
        if (in_valid) begin
          m_txn <= 1'b1; m_a <= a_in; m_b <= b_in; m_cap_at <= m_cyc + int'(S);
        end
      end else if (m_txn && !m_valid && m_cyc == m_cap_at) begin
        m_data  <= (m_a & m_b) & ~fault_mask;
        m_valid <= 1'b1;
        if (fault_mask != 8'h00 && ((m_a & m_b & fault_mask) != 8'h00)) m_mis <= 1'b1;
      end else if (m_valid && out_ready) begin
        m_txn <= 1'b0; m_valid <= 1'b0; m_cnt <= m_cnt + 8'd1;
      end
    end
  end

  initial m_cyc = 0;

  always @(negedge clk) begin
    check("in_ready", int'(in_ready), int'(m_rdy && !m_txn));
    check("busy", int'(busy), int'(m_txn));
    check("out_valid", int'(out_valid), int'(m_valid));
    check("out_data", int'(out_data), int'(m_data));
    check("and_a", int'(and_a), int'(m_a));
    check("and_b", int'(and_b), int'(m_b));
    check("mismatch", int'(mismatch), int'(m_mis));
    check("result_count", int'(result_count), int'(m_cnt));
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_and_a"}, int'(and_a), 0);
    check({tag, "_and_b"}, int'(and_b), 0);
    check({tag, "_mismatch"}, int'(mismatch), 0);
    check({tag, "_count"}, int'(result_count), 0);
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic send(input logic [7:0] a, input logic [7:0] b, output int lat);
    int k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) begin
      check("send_ready_timeout", 0, 1);
      lat = -1;
      return;
    end
    in_valid = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int lat, last_rise, done_n, lat1, lat15;
    logic prev_rdy;
    logic [7:0] d1, d15;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1 check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rdy_after_release", int'(in_ready), 0);
    @(negedge clk);
    check("rdy_first_edge", int'(in_ready), 1);

    // FF & 00 with downstream always ready
    out_ready = 1'b1;
    send(8'hFF, 8'h00, lat);
    check("lat_s2", lat, 2);
    check("t1_data", int'(out_data), 8'h00);
    @(negedge clk);
    check("t1_count", int'(result_count), 1);
    check("t1_mismatch", int'(mismatch), 0);

    // FF & A9 with a 5-cycle downstream stall and an ignored in_valid
    out_ready = 1'b0;
    send(8'hFF, 8'hA9, lat);
    for (int i = 0; i < 5; i++) begin
      check("stall_data", int'(out_data), 8'hA9);
      check("stall_and_a", int'(and_a), 8'hFF);
      check("stall_and_b", int'(and_b), 8'hA9);
      check("stall_count", int'(result_count), 1);
      in_valid = (i == 1);
      a_in = 8'h11; b_in = 8'h22;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stall_hold_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_count", int'(result_count), 2);
    check("t2_and_a_retained", int'(and_a), 8'hFF);

    // Faulty AND stage: S4 stuck low
    fault_mask = 8'h08;
    send(8'hFF, 8'hFF, lat);
    check("fault_data", int'(out_data), 8'hF7);
    check("fault_mismatch", int'(mismatch), 1);
    fault_mask = 8'h00;
    @(negedge clk);
    send(8'h3C, 8'h5A, lat);
    check("post_fault_data", int'(out_data), 8'h18);
    @(negedge clk);
    check("sticky_mismatch", int'(mismatch), 1);
    check("t4_count", int'(result_count), 4);

    // Reset mid-SETTLE aborts the transaction
    in_valid = 1'b1; a_in = 8'h12; b_in = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_settle_busy", int'(busy), 1);
    pulse_reset();
    send(8'h0F, 8'h3C, lat);
    check("post_rst_data", int'(out_data), 8'h0C);
    @(negedge clk);
    check("post_rst_count", int'(result_count), 1);

    // 256 back-to-back transactions: count wraps, fixed in_ready period
    pulse_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    last_rise = -1; done_n = 0; prev_rdy = 1'b0;
    for (int i = 0; i < 3000 && done_n < 256; i++) begin
      if (in_ready && !prev_rdy) begin
        if (last_rise >= 0) check("rdy_spacing", tb_cyc - last_rise, int'(S) + 2);
        last_rise = tb_cyc;
      end
      prev_rdy = in_ready;
      if (out_valid && out_ready) done_n++;
      if (done_n == 256) in_valid = 1'b0;
      a_in = 8'(i * 7); b_in = 8'(~(i * 3));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_done", done_n, 256);
    check("b2b_wrap", int'(result_count), 0);

    // SETTLE_CYCLES = 1 and 15 latencies
    @(negedge clk);
    in_valid_x = 1'b1; a_x = 8'hC3; b_x = 8'h5A;
    @(negedge clk);
    in_valid_x = 1'b0;
    lat1 = -1; lat15 = -1; d1 = '0; d15 = '0;
    for (int j = 0; j < 30; j++) begin
      if (lat1 < 0 && ov1) begin lat1 = j; d1 = od1; end
      if (lat15 < 0 && ov15) begin lat15 = j; d15 = od15; end
      @(negedge clk);
    end
    check("lat_s1", lat1, 1);
    check("lat_s15", lat15, 15);
    check("s1_data", int'(d1), 8'h42);
    check("s15_data", int'(d15), 8'h42);
    check("s1_count", int'(rc1), 1);
    check("s15_count", int'(rc15), 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
